// File: rtl/xge_gen_pkg.sv
// Shared types and helpers for the xge_mac simple-Tx frame generator.
// Byte k of a 64-bit word sits in bits [63-8k -: 8].
package xge_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam int DATA_W = 64;
  localparam int MOD_W  = 3;

  // Bytes beyond valid_bytes are zero so the eop word carries no stale pattern.
  function automatic logic [DATA_W-1:0] pattern_word(input logic [7:0] frame_idx,
                                                     input logic [7:0] byte_base,
                                                     input logic [3:0] valid_bytes);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      if (k < int'(valid_bytes))
        w[DATA_W-1-8*k -: 8] = frame_idx + byte_base + 8'(k);
    return w;
  endfunction
endpackage

// File: rtl/xge_pkt_tx_gen.sv
// Frame source for the xge_mac pkt_tx_* interface: counted or continuous runs of
// fixed-length pattern frames with a programmable inter-frame gap and backpressure.
module xge_pkt_tx_gen
  import xge_gen_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       cfg_frame_len,
  input  logic [15:0]       cfg_frame_cnt,
  input  logic [7:0]        cfg_gap,
  input  logic              pkt_tx_full,
  output logic [DATA_W-1:0] pkt_tx_data,
  output logic              pkt_tx_val,
  output logic              pkt_tx_sop,
  output logic              pkt_tx_eop,
  output logic [MOD_W-1:0]  pkt_tx_mod,
  output logic              busy,
  output logic              done,
  output logic [31:0]       frames_sent
);
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  state_t            state, state_nxt;
  logic [7:0]        widx, widx_nxt;
  logic [7:0]        gap_cnt, gap_nxt;
  logic [15:0]       fidx, fidx_nxt;
  logic              abort_pend, abort_nxt;
  logic [15:0]       cnt_q;
  logic [7:0]        gap_q;
  logic [7:0]        last_widx;
  logic [MOD_W-1:0]  eop_mod;

  logic [15:0]       len_cl;
  logic [7:0]        words_m1;
  logic              is_eop, last_frame, load_cfg;
  logic [3:0]        eop_bytes;

  logic [DATA_W-1:0] data_nxt;
  logic              val_nxt, sop_nxt, eop_nxt, busy_nxt, done_nxt;
  logic [MOD_W-1:0]  mod_nxt;
  logic [31:0]       sent_nxt;

  always_comb begin
    len_cl = cfg_frame_len;
    if (cfg_frame_len < MIN_L)      len_cl = MIN_L;
    else if (cfg_frame_len > MAX_L) len_cl = MAX_L;
  end

  // Clamped length never exceeds MAX_LEN, so the word count fits in 8 bits.
  assign words_m1   = 8'(((len_cl + 16'd7) >> 3) - 16'd1);
  assign is_eop     = (widx == last_widx);
  assign last_frame = (cnt_q != 16'd0) && (fidx == cnt_q - 16'd1);
  assign eop_bytes  = (eop_mod == '0) ? 4'd8 : {1'b0, eop_mod};

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    widx_nxt  = widx;
    gap_nxt   = gap_cnt;
    fidx_nxt  = fidx;
    abort_nxt = abort_pend;
    load_cfg  = 1'b0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    val_nxt   = 1'b0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    mod_nxt   = '0;
    data_nxt  = '0;
    sent_nxt  = frames_sent;
    case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (start) begin
          state_nxt = SEND;
          load_cfg  = 1'b1;
          busy_nxt  = 1'b1;
          widx_nxt  = '0;
          fidx_nxt  = '0;
        end
      end
      SEND: begin
        abort_nxt = abort_pend | abort;
        if (!pkt_tx_full) begin
          val_nxt  = 1'b1;
          sop_nxt  = (widx == 8'd0);
          eop_nxt  = is_eop;
          data_nxt = pattern_word(fidx[7:0], {widx[4:0], 3'b000}, is_eop ? eop_bytes : 4'd8);
          if (is_eop) begin
            mod_nxt  = eop_mod;
            sent_nxt = frames_sent + 32'd1;
            widx_nxt = '0;
            fidx_nxt = fidx + 16'd1;
            if (abort_nxt || last_frame) begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else if (gap_q != 8'd0) begin
              state_nxt = GAP;
              gap_nxt   = gap_q;
            end
          end else begin
            widx_nxt = widx + 8'd1;
          end
        end
      end
      GAP: begin
        abort_nxt = abort_pend | abort;
        if (abort_nxt) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (!pkt_tx_full) begin
          // The last gap cycle hands over so the sop lands on the following edge.
          if (gap_cnt <= 8'd1) state_nxt = SEND;
          else                 gap_nxt   = gap_cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      widx        <= '0;
      gap_cnt     <= '0;
      fidx        <= '0;
      abort_pend  <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      last_widx   <= '0;
      eop_mod     <= '0;
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      widx        <= widx_nxt;
      gap_cnt     <= gap_nxt;
      fidx        <= fidx_nxt;
      abort_pend  <= abort_nxt;
      if (load_cfg) begin
        cnt_q     <= cfg_frame_cnt;
        gap_q     <= cfg_gap;
        last_widx <= words_m1;
        eop_mod   <= len_cl[2:0];
      end
      pkt_tx_data <= data_nxt;
      pkt_tx_val  <= val_nxt;
      pkt_tx_sop  <= sop_nxt;
      pkt_tx_eop  <= eop_nxt;
      pkt_tx_mod  <= mod_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      frames_sent <= sent_nxt;
    end
  end
endmodule

// File: tb/tb_xge_pkt_tx_gen.sv
// Scenario bench for xge_pkt_tx_gen; expected frames come from a byte-level model
// built straight from the length/pattern rules.
module tb_xge_pkt_tx_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, full = 1'b0;
  logic [15:0] cfg_len = '0, cfg_cnt = '0;
  logic [7:0]  cfg_gap = '0;
  logic [63:0] data;
  logic        val, sop, eop, busy, done;
  logic [2:0]  mod;
  logic [31:0] frames_sent;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [63:0] data;
  } word_t;

  word_t obs_q[$], exp_q[$];
  word_t mw;
  int    sop_cyc[$], eop_cyc[$];
  int    cyc = 0, done_cnt = 0, bad_idle = 0;
  int    checks = 0, errors = 0;
  bit    rand_full = 1'b0;

  always #5 clk = ~clk;

  xge_pkt_tx_gen dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n), .start(start), .abort(abort),
    .cfg_frame_len(cfg_len), .cfg_frame_cnt(cfg_cnt), .cfg_gap(cfg_gap),
    .pkt_tx_full(full), .pkt_tx_data(data), .pkt_tx_val(val), .pkt_tx_sop(sop),
    .pkt_tx_eop(eop), .pkt_tx_mod(mod), .busy(busy), .done(done),
    .frames_sent(frames_sent)
  );

  always @(negedge clk) begin
    cyc++;
    if (val) begin
      mw = {sop, eop, mod, data};
      obs_q.push_back(mw);
      if (sop) sop_cyc.push_back(cyc);
      if (eop) eop_cyc.push_back(cyc);
    end else if (data != 64'd0 || sop || eop || mod != 3'd0) begin
      bad_idle++;
    end
    if (done) done_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_full) full = ($urandom_range(0, 3) == 0);
  end

  // Reference: clamp, then byte i of frame n is (n+i) mod 256, zero past the frame end.
  task automatic build_exp(input int len, input int nframes);
    int    L, W, bi;
    word_t w;
    L = (len < 64) ? 64 : ((len > 1518) ? 1518 : len);
    W = (L + 7) / 8;
    for (int n = 0; n < nframes; n++)
      for (int wi = 0; wi < W; wi++) begin
        w.data = '0;
        for (int k = 0; k < 8; k++) begin
          bi = wi * 8 + k;
          if (bi < L) w.data[63-8*k -: 8] = 8'((n + bi) % 256);
        end
        w.sop = (wi == 0);
        w.eop = (wi == W - 1);
        w.mod = (wi == W - 1) ? 3'(L % 8) : 3'd0;
        exp_q.push_back(w);
      end
  endtask

  task automatic clear_obs();
    obs_q.delete(); exp_q.delete(); sop_cyc.delete(); eop_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rand_full = 1'b0; full = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    @(posedge clk); #1;
  endtask

  // Drives one start pulse, then scrambles cfg_* to show mid-run changes are ignored.
  task automatic start_run(input int len, input int cnt, input int gap);
    @(posedge clk); #1;
    cfg_len = 16'(len); cfg_cnt = 16'(cnt); cfg_gap = 8'(gap); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_len = 16'($urandom); cfg_cnt = 16'($urandom); cfg_gap = 8'($urandom);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(posedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({val, sop, eop, mod, data, busy, done, frames_sent} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got val=%b busy=%b data=%h sent=%0d want all 0", val, busy, data, frames_sent);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    do_reset();
    build_exp(64, 1);
    start_run(64, 1, 0);
    checks++;
    if (busy !== 1'b1 || val !== 1'b0) begin
      errors++; $display("FAIL start_latency got busy=%b val=%b want busy=1 val=0", busy, val);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout no done within bound"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].data !== 64'h0001020304050607) begin
      errors++; $display("FAIL single_sop_data got %h want 0001020304050607", obs_q[0].data);
    end
    checks++;
    if (done_cnt != 1 || frames_sent !== 32'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_end got done=%0d sent=%0d busy=%b want 1 1 0", done_cnt, frames_sent, busy);
    end
  endtask

  task automatic test_gap();
    bit ok;
    do_reset();
    build_exp(65, 2);
    start_run(65, 2, 3);
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL gap_timeout no done within bound"); end
    checks++;
    if (obs_q.size() != 18) begin errors++; $display("FAIL gap_count got %0d want 18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gap_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sop_cyc.size() != 2 || eop_cyc.size() != 2) begin
      errors++; $display("FAIL gap_markers got sop=%0d eop=%0d want 2 2", sop_cyc.size(), eop_cyc.size());
    end else if (sop_cyc[1] - eop_cyc[0] - 1 != 3) begin
      errors++; $display("FAIL gap_idle got %0d idle cycles want 3", sop_cyc[1] - eop_cyc[0] - 1);
    end
    checks++;
    if (done_cnt != 1 || frames_sent !== 32'd2) begin
      errors++; $display("FAIL gap_end got done=%0d sent=%0d want 1 2", done_cnt, frames_sent);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int nw;
    do_reset();
    build_exp(128, 1);
    start_run(128, 1, 0);
    nw = 0;
    for (int c = 0; c < 100 && nw < 3; c++) begin
      @(negedge clk);
      if (val) nw++;
    end
    full = 1'b1;
    repeat (5) @(posedge clk);
    #1 full = 1'b0;
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout no done within bound"); end
    checks++;
    if (obs_q.size() != 16) begin errors++; $display("FAIL bp_count got %0d want 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sop_cyc.size() != 1 || eop_cyc.size() != 1) begin
      errors++; $display("FAIL bp_markers got sop=%0d eop=%0d want 1 1", sop_cyc.size(), eop_cyc.size());
    end else if (eop_cyc[0] - sop_cyc[0] + 1 != 21) begin
      errors++; $display("FAIL bp_span got %0d cycles want 21", eop_cyc[0] - sop_cyc[0] + 1);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int nsop, wi;
    do_reset();
    build_exp(64, 3);
    abort = 1'b1;                 // held through an idle edge and the start edge
    start_run(64, 0, 2);
    abort = 1'b0;
    nsop = 0; wi = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (val) begin
        if (sop) begin nsop++; wi = 0; end else wi++;
        if (nsop == 3 && wi == 3) break;
      end
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_timeout no done within bound"); end
    checks++;
    if (obs_q.size() != 24) begin errors++; $display("FAIL abort_count got %0d want 24", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || frames_sent !== 32'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_end got done=%0d sent=%0d busy=%b want 1 3 0", done_cnt, frames_sent, busy);
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int lens[2] = '{20, 4000};
    int wants[2] = '{8, 190};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      clear_obs();
      build_exp(lens[r], 1);
      start_run(lens[r], 1, 0);
      wait_done(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL clamp%0d_timeout no done within bound", lens[r]); end
      checks++;
      if (obs_q.size() != wants[r]) begin
        errors++; $display("FAIL clamp%0d_count got %0d want %0d", lens[r], obs_q.size(), wants[r]);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL clamp%0d_word%0d got %h want %h", lens[r], i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[obs_q.size()-1].mod !== 3'd6) begin
      errors++; $display("FAIL clamp_mod got %0d want 6", obs_q[obs_q.size()-1].mod);
    end
  endtask

  task automatic test_random();
    bit ok;
    int len, cnt, gap, total;
    do_reset();
    total = 0;
    for (int r = 0; r < 4; r++) begin
      clear_obs();
      len = $urandom_range(1, 1700);
      cnt = $urandom_range(1, 3);
      gap = $urandom_range(0, 5);
      total += cnt;
      build_exp(len, cnt);
      rand_full = 1'b1;
      start_run(len, cnt, gap);
      wait_done(8000, ok);
      rand_full = 1'b0;
      @(negedge clk); full = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_timeout len=%0d no done", r, len); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d want %0d", r, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_word%0d got %h want %h", r, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (frames_sent !== 32'(total)) begin
        errors++; $display("FAIL rand%0d_sent got %0d want %0d", r, frames_sent, total);
      end
    end
    checks++;
    if (bad_idle != 0) begin errors++; $display("FAIL idle_data got %0d dirty idle cycles want 0", bad_idle); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int nw;
    do_reset();
    start_run(64, 3, 0);
    nw = 0;
    for (int c = 0; c < 100 && nw < 12; c++) begin
      @(negedge clk);
      if (val) nw++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({val, sop, eop, mod, data, busy, done, frames_sent} !== '0) begin
      errors++; $display("FAIL async_reset got val=%b busy=%b data=%h sent=%0d want all 0", val, busy, data, frames_sent);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_obs();
    build_exp(64, 1);
    start_run(64, 1, 0);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rerun_timeout no done within bound"); end
    checks++;
    if (obs_q.size() != 8 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL rerun_first got n=%0d w0=%h want n=8 w0=%h", obs_q.size(),
                         (obs_q.size() > 0) ? obs_q[0] : word_t'(0), exp_q[0]);
    end
    checks++;
    if (frames_sent !== 32'd1) begin errors++; $display("FAIL rerun_sent got %0d want 1", frames_sent); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gap();
    test_backpressure();
    test_abort();
    test_clamp();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
